// File: rtl/alu_operand_fwd_stage_pkg.sv
// Shared constants for the ALU operand forwarding stage: forwarding tags,
// default widths (matching the DATA_BUS width) and the operand source indices.
package alu_operand_fwd_stage_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int REG_ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_tag_e;

    localparam int SRC_T    = 0;
    localparam int SRC_SP   = 1;
    localparam int SRC_RZ   = 2;
    localparam int SRC_REGA = 3;

endpackage

// File: rtl/alu_operand_fwd_stage_hit_unit.sv
// Register-address match logic shared by the operand and branch hazard paths:
// produces EX/MEM and MEM/WB hits, the forwarding tag and the load-use request.
module fwd_hit_unit
    import alu_operand_fwd_stage_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  in_valid,
    input  logic                  flush,
    input  logic                  src_is_reg,
    input  logic [REG_ADDR_W-1:0] src_reg_addr,
    input  logic                  exmem_wr_en,
    input  logic [REG_ADDR_W-1:0] exmem_wr_addr,
    input  logic                  exmem_is_load,
    input  logic                  memwb_wr_en,
    input  logic [REG_ADDR_W-1:0] memwb_wr_addr,
    output logic                  hit_ex,
    output logic                  hit_wb,
    output fwd_tag_e              tag,
    output logic                  load_use_stall
);

    always_comb begin
        hit_ex = src_is_reg & exmem_wr_en & (exmem_wr_addr == src_reg_addr);
        hit_wb = src_is_reg & memwb_wr_en & (memwb_wr_addr == src_reg_addr);

        // A load in EX/MEM cannot forward yet, so an older MEM/WB match may win.
        if (hit_ex && !exmem_is_load) begin
            tag = FWD_EXMEM;
        end else if (hit_wb) begin
            tag = FWD_MEMWB;
        end else begin
            tag = FWD_NONE;
        end

        load_use_stall = in_valid & hit_ex & exmem_is_load & ~flush;
    end

endmodule

// File: rtl/alu_operand_fwd_stage.sv
// ID/EX operand latch for one ALU operand: source select, EX/MEM and MEM/WB
// forwarding, load-use bubble insertion and a saturating bubble counter.
module alu_operand_fwd_stage
    import alu_operand_fwd_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic                      src_is_reg,
    input  logic [REG_ADDR_W-1:0]     src_reg_addr,
    input  logic                      exmem_wr_en,
    input  logic [REG_ADDR_W-1:0]     exmem_wr_addr,
    input  logic [DATA_W-1:0]         exmem_wr_data,
    input  logic                      exmem_is_load,
    input  logic                      memwb_wr_en,
    input  logic [REG_ADDR_W-1:0]     memwb_wr_addr,
    input  logic [DATA_W-1:0]         memwb_wr_data,
    input  logic                      stall_in,
    input  logic                      flush,
    output logic                      load_use_stall,
    output logic [DATA_W-1:0]         op_data,
    output logic                      op_valid,
    output logic [1:0]                fwd_src,
    output logic [CNT_W-1:0]          hazard_cnt
);

    logic              hit_ex;
    logic              hit_wb;
    fwd_tag_e          tag;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] fwd;

    logic [DATA_W-1:0] op_data_q,    op_data_d;
    logic              op_valid_q,   op_valid_d;
    fwd_tag_e          fwd_src_q,    fwd_src_d;
    logic [CNT_W-1:0]  hazard_cnt_q, hazard_cnt_d;

    fwd_hit_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hit (
        .in_valid       (in_valid),
        .flush          (flush),
        .src_is_reg     (src_is_reg),
        .src_reg_addr   (src_reg_addr),
        .exmem_wr_en    (exmem_wr_en),
        .exmem_wr_addr  (exmem_wr_addr),
        .exmem_is_load  (exmem_is_load),
        .memwb_wr_en    (memwb_wr_en),
        .memwb_wr_addr  (memwb_wr_addr),
        .hit_ex         (hit_ex),
        .hit_wb         (hit_wb),
        .tag            (tag),
        .load_use_stall (load_use_stall)
    );

    // Unpopulated select codes read as zero rather than aliasing a real source.
    always_comb begin
        base = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(src_sel) == i) begin
                base = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        if (hit_ex && !exmem_is_load) begin
            fwd = exmem_wr_data;
        end else if (hit_wb) begin
            fwd = memwb_wr_data;
        end else begin
            fwd = base;
        end
    end

    // Flush beats stall, and a stalled stage neither bubbles nor counts.
    always_comb begin
        op_data_d    = op_data_q;
        op_valid_d   = op_valid_q;
        fwd_src_d    = fwd_src_q;
        hazard_cnt_d = hazard_cnt_q;
        if (flush) begin
            op_valid_d = 1'b0;
            fwd_src_d  = FWD_NONE;
        end else if (stall_in) begin
            op_valid_d = op_valid_q;
        end else if (load_use_stall) begin
            op_valid_d = 1'b0;
            fwd_src_d  = FWD_NONE;
            if (hazard_cnt_q != {CNT_W{1'b1}}) begin
                hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
            end
        end else begin
            op_data_d  = fwd;
            op_valid_d = in_valid;
            fwd_src_d  = in_valid ? tag : FWD_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_data_q    <= '0;
            op_valid_q   <= 1'b0;
            fwd_src_q    <= FWD_NONE;
            hazard_cnt_q <= '0;
        end else begin
            op_data_q    <= op_data_d;
            op_valid_q   <= op_valid_d;
            fwd_src_q    <= fwd_src_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign op_data    = op_data_q;
    assign op_valid   = op_valid_q;
    assign fwd_src    = fwd_src_q;
    assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_alu_operand_fwd_stage.sv
// Bench for alu_operand_fwd_stage: a default instance and a narrow one
// (NUM_SRC=3, CNT_W=2) share stimulus and are checked against a rule model.
module tb_alu_operand_fwd_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] src_data;
    logic [1:0]  src_sel;
    logic        src_is_reg;
    logic [3:0]  src_reg_addr;
    logic        exmem_wr_en;
    logic [3:0]  exmem_wr_addr;
    logic [15:0] exmem_wr_data;
    logic        exmem_is_load;
    logic        memwb_wr_en;
    logic [3:0]  memwb_wr_addr;
    logic [15:0] memwb_wr_data;
    logic        stall_in;
    logic        flush;

    logic        lus0, lus1;
    logic [15:0] op_data0, op_data1;
    logic        op_valid0, op_valid1;
    logic [1:0]  fwd_src0, fwd_src1;
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;

    int total = 0;
    int bad   = 0;

    // Expected register state per instance: [0] default, [1] narrow.
    logic [15:0] exp_data  [2];
    logic        exp_valid [2];
    logic [1:0]  exp_fwd   [2];
    int          exp_cnt   [2];
    int          cnt_max   [2] = '{255, 3};
    int          nsrc      [2] = '{4, 3};

    always #5 clk = ~clk;

    alu_operand_fwd_stage dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .src_data(src_data),
        .src_sel(src_sel), .src_is_reg(src_is_reg), .src_reg_addr(src_reg_addr),
        .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
        .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
        .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
        .memwb_wr_data(memwb_wr_data), .stall_in(stall_in), .flush(flush),
        .load_use_stall(lus0), .op_data(op_data0), .op_valid(op_valid0),
        .fwd_src(fwd_src0), .hazard_cnt(cnt0)
    );

    alu_operand_fwd_stage #(.NUM_SRC(3), .SEL_W(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .src_data(src_data[47:0]),
        .src_sel(src_sel), .src_is_reg(src_is_reg), .src_reg_addr(src_reg_addr),
        .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr),
        .exmem_wr_data(exmem_wr_data), .exmem_is_load(exmem_is_load),
        .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr),
        .memwb_wr_data(memwb_wr_data), .stall_in(stall_in), .flush(flush),
        .load_use_stall(lus1), .op_data(op_data1), .op_valid(op_valid1),
        .fwd_src(fwd_src1), .hazard_cnt(cnt1)
    );

    function automatic bit m_hit_ex();
        return src_is_reg && exmem_wr_en && (exmem_wr_addr == src_reg_addr);
    endfunction

    function automatic bit m_hit_wb();
        return src_is_reg && memwb_wr_en && (memwb_wr_addr == src_reg_addr);
    endfunction

    function automatic bit m_lus();
        return in_valid && m_hit_ex() && exmem_is_load && !flush;
    endfunction

    function automatic logic [1:0] m_tag();
        if (m_hit_ex() && !exmem_is_load) return 2'd1;
        if (m_hit_wb()) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [15:0] m_operand(int n);
        int sel = int'(src_sel);
        if (m_tag() == 2'd1) return exmem_wr_data;
        if (m_tag() == 2'd2) return memwb_wr_data;
        if (sel >= n) return 16'h0000;
        return src_data[sel*16 +: 16];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_data[k] = 16'h0; exp_valid[k] = 1'b0; exp_fwd[k] = 2'd0; exp_cnt[k] = 0;
        end
    endtask

    // Advance the model with the current inputs, then pass one rising edge.
    task automatic cycle();
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                exp_valid[k] = 1'b0; exp_fwd[k] = 2'd0;
            end else if (stall_in) begin
                exp_valid[k] = exp_valid[k];
            end else if (m_lus()) begin
                exp_valid[k] = 1'b0; exp_fwd[k] = 2'd0;
                if (exp_cnt[k] < cnt_max[k]) exp_cnt[k] = exp_cnt[k] + 1;
            end else begin
                exp_data[k]  = m_operand(nsrc[k]);
                exp_valid[k] = in_valid;
                exp_fwd[k]   = in_valid ? m_tag() : 2'd0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; src_data = '0; src_sel = 0; src_is_reg = 0; src_reg_addr = 0;
        exmem_wr_en = 0; exmem_wr_addr = 0; exmem_wr_data = 0; exmem_is_load = 0;
        memwb_wr_en = 0; memwb_wr_addr = 0; memwb_wr_data = 0; stall_in = 0; flush = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({op_data0, op_valid0, fwd_src0, cnt0} !== 27'h0) begin
            bad++; $display("[TB] FAIL reset_dut0 got=%h want=0", {op_data0, op_valid0, fwd_src0, cnt0});
        end
        total++;
        if ({op_data1, op_valid1, fwd_src1, cnt1} !== 21'h0) begin
            bad++; $display("[TB] FAIL reset_dut1 got=%h want=0", {op_data1, op_valid1, fwd_src1, cnt1});
        end
        total++;
        if ({lus0, lus1} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_lus got=%b want=00", {lus0, lus1});
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_plain_select();
        set_idle();
        in_valid = 1; src_sel = 2; src_data[32 +: 16] = 16'h1234;
        cycle();
        total++;
        if ({op_data0, op_valid0, fwd_src0} !== {16'h1234, 1'b1, 2'd0}) begin
            bad++; $display("[TB] FAIL plain_select got=%h/%b/%0d want=1234/1/0", op_data0, op_valid0, fwd_src0);
        end
    endtask

    task automatic test_dual_hit();
        set_idle();
        in_valid = 1; src_is_reg = 1; src_reg_addr = 3; src_sel = 0;
        exmem_wr_en = 1; exmem_wr_addr = 3; exmem_wr_data = 16'hAAAA;
        memwb_wr_en = 1; memwb_wr_addr = 3; memwb_wr_data = 16'h5555;
        cycle();
        total++;
        if ({op_data0, fwd_src0} !== {16'hAAAA, 2'd1}) begin
            bad++; $display("[TB] FAIL dual_hit got=%h/%0d want=aaaa/1", op_data0, fwd_src0);
        end
    endtask

    task automatic test_load_use();
        set_idle();
        in_valid = 1; src_is_reg = 1; src_reg_addr = 5;
        exmem_wr_en = 1; exmem_wr_addr = 5; exmem_is_load = 1; exmem_wr_data = 16'hDEAD;
        #1;
        total++;
        if (lus0 !== 1'b1) begin
            bad++; $display("[TB] FAIL load_use_req got=%b want=1", lus0);
        end
        cycle();
        total++;
        if ({op_valid0, fwd_src0, cnt0, cnt1} !== {1'b0, 2'd0, 8'd1, 2'd1}) begin
            bad++; $display("[TB] FAIL load_use_bubble got=%b/%0d/%0d/%0d want=0/0/1/1", op_valid0, fwd_src0, cnt0, cnt1);
        end
        exmem_wr_en = 0; exmem_is_load = 0;
        memwb_wr_en = 1; memwb_wr_addr = 5; memwb_wr_data = 16'h0F0F;
        #1;
        total++;
        if (lus0 !== 1'b0) begin
            bad++; $display("[TB] FAIL load_use_recover_req got=%b want=0", lus0);
        end
        cycle();
        total++;
        if ({op_data0, op_valid0, fwd_src0, cnt0} !== {16'h0F0F, 1'b1, 2'd2, 8'd1}) begin
            bad++; $display("[TB] FAIL load_use_recover got=%h/%b/%0d/%0d want=0f0f/1/2/1", op_data0, op_valid0, fwd_src0, cnt0);
        end
    endtask

    task automatic test_stall_flush();
        set_idle();
        in_valid = 1; src_sel = 1; src_data[16 +: 16] = 16'hBEEF;
        cycle();
        for (int c = 0; c < 3; c++) begin
            src_data = {$urandom, $urandom}; src_sel = 2'($urandom);
            src_is_reg = 1; src_reg_addr = 4'($urandom);
            exmem_wr_en = 1; exmem_wr_addr = src_reg_addr; exmem_is_load = (c == 1);
            exmem_wr_data = 16'($urandom); stall_in = 1;
            cycle();
            total++;
            if ({op_data0, op_valid0, fwd_src0, cnt0} !== {16'hBEEF, 1'b1, 2'd0, 8'(exp_cnt[0])}) begin
                bad++; $display("[TB] FAIL stall_hold cyc=%0d got=%h/%b/%0d/%0d want=beef/1/0/%0d", c, op_data0, op_valid0, fwd_src0, cnt0, exp_cnt[0]);
            end
        end
        flush = 1;
        cycle();
        total++;
        if ({op_data0, op_valid0, fwd_src0} !== {16'hBEEF, 1'b0, 2'd0}) begin
            bad++; $display("[TB] FAIL flush_over_stall got=%h/%b/%0d want=beef/0/0", op_data0, op_valid0, fwd_src0);
        end
        stall_in = 0; exmem_is_load = 1; exmem_wr_addr = src_reg_addr;
        #1;
        total++;
        if ({lus0, lus1} !== 2'b00) begin
            bad++; $display("[TB] FAIL flush_kills_lus got=%b want=00", {lus0, lus1});
        end
        cycle();
        total++;
        if (cnt0 !== 8'(exp_cnt[0]) || op_valid0 !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_no_count got=%0d/%b want=%0d/0", cnt0, op_valid0, exp_cnt[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            in_valid = ($urandom_range(0, 9) != 0);
            src_data = {$urandom, $urandom};
            src_sel = 2'($urandom);
            src_is_reg = ($urandom_range(0, 3) != 0);
            src_reg_addr = 4'($urandom_range(0, 3));
            exmem_wr_en = 1'($urandom); exmem_wr_addr = 4'($urandom_range(0, 3));
            exmem_wr_data = 16'($urandom); exmem_is_load = ($urandom_range(0, 3) == 0);
            memwb_wr_en = 1'($urandom); memwb_wr_addr = 4'($urandom_range(0, 3));
            memwb_wr_data = 16'($urandom);
            stall_in = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            #1;
            total++;
            if (lus0 !== m_lus() || lus1 !== m_lus()) begin
                bad++; $display("[TB] FAIL rand_lus n=%0d got=%b%b want=%b", n, lus0, lus1, m_lus());
            end
            cycle();
            total++;
            if ({op_data0, op_valid0, fwd_src0, cnt0} !== {exp_data[0], exp_valid[0], exp_fwd[0], 8'(exp_cnt[0])}) begin
                bad++; $display("[TB] FAIL rand_dut0 n=%0d got=%h/%b/%0d/%0d want=%h/%b/%0d/%0d", n, op_data0, op_valid0, fwd_src0, cnt0, exp_data[0], exp_valid[0], exp_fwd[0], exp_cnt[0]);
            end
            total++;
            if ({op_data1, op_valid1, fwd_src1, cnt1} !== {exp_data[1], exp_valid[1], exp_fwd[1], 2'(exp_cnt[1])}) begin
                bad++; $display("[TB] FAIL rand_dut1 n=%0d got=%h/%b/%0d/%0d want=%h/%b/%0d/%0d", n, op_data1, op_valid1, fwd_src1, cnt1, exp_data[1], exp_valid[1], exp_fwd[1], exp_cnt[1]);
            end
        end
    endtask

    task automatic test_saturation();
        set_idle();
        in_valid = 1; src_is_reg = 1; src_reg_addr = 7;
        exmem_wr_en = 1; exmem_wr_addr = 7; exmem_is_load = 1;
        for (int b = 0; b < 5; b++) cycle();
        total++;
        if (cnt1 !== 2'd3) begin
            bad++; $display("[TB] FAIL sat_cnt_narrow got=%0d want=3", cnt1);
        end
        total++;
        if (cnt0 !== 8'(exp_cnt[0])) begin
            bad++; $display("[TB] FAIL sat_cnt_wide got=%0d want=%0d", cnt0, exp_cnt[0]);
        end
        stall_in = 1;
        #2 rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({op_data0, op_valid0, fwd_src0, cnt0, op_data1, op_valid1, fwd_src1, cnt1} !== 48'h0) begin
            bad++; $display("[TB] FAIL async_reset got=%h/%b/%0d/%0d %h/%b/%0d/%0d want=all0", op_data0, op_valid0, fwd_src0, cnt0, op_data1, op_valid1, fwd_src1, cnt1);
        end
        rst = 1'b0;
        stall_in = 0;
    endtask

    task automatic test_out_of_range();
        set_idle();
        in_valid = 1; src_sel = 3; src_data = 64'hCAFE_3333_2222_1111;
        cycle();
        total++;
        if (op_data1 !== 16'h0000 || op_valid1 !== 1'b1) begin
            bad++; $display("[TB] FAIL oor_select got=%h/%b want=0000/1", op_data1, op_valid1);
        end
        total++;
        if (op_data0 !== 16'hCAFE) begin
            bad++; $display("[TB] FAIL sel3_wide got=%h want=cafe", op_data0);
        end
    endtask

    initial begin
        test_reset();
        test_plain_select();
        test_dual_hit();
        test_load_use();
        test_stall_flush();
        test_random();
        test_saturation();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/alu_operand_fwd_stage.md
Name: alu_operand_fwd_stage

Overview:
- Parametrised successor to the ALU operand-A selector.
- Selects one of NUM_SRC operand sources and overrides it with forwarded data from EX/MEM or MEM/WB on a register-address match.
- Detects load-use hazards and inserts a bubble.
- Registers the result as the ID/EX operand latch, with stall/flush control and a saturating hazard counter.
- One instance per ALU operand (A and B) in the 5-stage pipeline.

Parameters:
- DATA_W, 16, operand width.
- REG_ADDR_W, 4, register-file address width (GPRs plus T/SP/IH encodings).
- NUM_SRC, 4, number of non-forwarded operand sources.
- SEL_W, 2, width of src_sel; must satisfy 2**SEL_W >= NUM_SRC.
- CNT_W, 8, hazard counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  ID-stage instruction valid.
- src_data  in  NUM_SRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W].
- src_sel  in  SEL_W  source index.
- src_is_reg  in  1  selected source is a register-file read, so it is forwardable.
- src_reg_addr  in  REG_ADDR_W  register read by the selected source.
- exmem_wr_en  in  1  EX/MEM instruction writes a register.
- exmem_wr_addr  in  REG_ADDR_W  EX/MEM destination register.
- exmem_wr_data  in  DATA_W  EX/MEM ALU result.
- exmem_is_load  in  1  EX/MEM instruction is a load; its data is not yet available.
- memwb_wr_en  in  1  MEM/WB instruction writes a register.
- memwb_wr_addr  in  REG_ADDR_W  MEM/WB destination register.
- memwb_wr_data  in  DATA_W  MEM/WB writeback data.
- stall_in  in  1  downstream stall; hold the latch.
- flush  in  1  kill the latched operand.
- load_use_stall  out  1  combinational request to hold IF/ID.
- op_data  out  DATA_W  registered operand.
- op_valid  out  1  registered valid.
- fwd_src  out  2  registered forwarding tag: 0 = none, 1 = EX/MEM, 2 = MEM/WB.
- hazard_cnt  out  CNT_W  saturating count of inserted load-use bubbles.

Behaviour:
- Reset: asynchronous on rst high. op_data=0, op_valid=0, fwd_src=0, hazard_cnt=0. load_use_stall follows its combinational equation and is 0 whenever in_valid=0.
- Base select: base = src_data[src_sel]. If src_sel >= NUM_SRC, base = 0.
- hit_ex = src_is_reg & exmem_wr_en & (exmem_wr_addr == src_reg_addr).
- hit_wb = src_is_reg & memwb_wr_en & (memwb_wr_addr == src_reg_addr).
- Forwarding priority (youngest producer wins):
  - hit_ex & !exmem_is_load: fwd = exmem_wr_data, tag 1.
  - else hit_wb: fwd = memwb_wr_data, tag 2.
  - else fwd = base, tag 0.
- Load-use: load_use_stall = in_valid & hit_ex & exmem_is_load & !flush. Combinational, same cycle.
- Latch update at the rising edge, first matching rule applies:
  1. flush: op_valid<=0, fwd_src<=0, op_data held. Flush wins over stall and load-use.
  2. stall_in: all registers hold. No bubble and no count while stalled, even if load_use_stall=1.
  3. load_use_stall: op_valid<=0 (bubble), fwd_src<=0, hazard_cnt increments.
  4. Otherwise: op_data<=fwd, op_valid<=in_valid, fwd_src<=tag (0 when in_valid=0).
- Load-use recovery: upstream holds the instruction. The next cycle the load sits in MEM/WB, hit_wb selects it, and there is no second bubble.
- hazard_cnt saturates at 2**CNT_W-1. Only reset clears it.
- Latency: one cycle from ID inputs to op_data/op_valid.
- Width rule: all data paths are exactly DATA_W bits; no extension or truncation.
- A rst pulse mid-stall clears everything immediately, independent of clk.

Decomposition:
- Shared package/define file holds:
  - FWD_NONE/FWD_EXMEM/FWD_MEMWB tag constants.
  - DATA_W/REG_ADDR_W defaults, consistent with the existing DATA_BUS define.
  - Source index constants for T, SP, RZ, REGA.
- One natural sub-module: fwd_hit_unit. It is combinational and produces hit_ex, hit_wb, tag and load_use_stall, so the branch hazard logic can reuse it.
- The mux and latch stay in the top module.

Test Plan:
- Plain select: src_sel=2, src_data[2]=16'h1234, no hits, in_valid=1 -> next cycle op_data=16'h1234, op_valid=1, fwd_src=0.
- Dual hit priority: src_reg_addr=3, EX/MEM (wr_en=1, addr=3, data=16'hAAAA, not load) and MEM/WB (addr=3, data=16'h5555) -> op_data=16'hAAAA, fwd_src=1.
- Load-use: EX/MEM load to r5, src_reg_addr=5:
  - Cycle 0: load_use_stall=1. Next edge: op_valid=0, hazard_cnt=1.
  - Cycle 1: MEM/WB addr=5, data=16'h0F0F -> op_data=16'h0F0F, fwd_src=2, no further stall.
- Stall/flush precedence:
  - stall_in=1 with changing inputs -> outputs hold for 3 cycles.
  - flush=1 with stall_in=1 -> op_valid=0.
  - Load-use concurrent with flush -> load_use_stall=0.
- Saturation and reset: CNT_W=2, 5 load-use bubbles -> hazard_cnt=3. Assert rst between clock edges -> all outputs 0 immediately.
- Out-of-range select: NUM_SRC=3, src_sel=3, no hits -> op_data=0.
